sweep_scheduler: RTL and testbench

- Sequences one raster sweep of the environment grid per game tick.
- Drives the lookup (view) location and a lagged write location, plus the write_flag consumed by environment, env_cache, ants and sugar patches.
- Replaces free-running location counters with a deterministic, pausable, abortable sweep.
- Sits between the game-clock divider and the environment/ant datapath, clocked by newLocClock.

---
 rtl/sweep_scheduler.sv | 143 ++++++++++++++
 tb/tb_sweep_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
// Raster sweep sequencer: one (X_MAX+1)x(Y_MAX+1) pass per accepted tick; writes trail view by LAG cycles.
// pause freezes view and pipeline; run=0 aborts; ticks while busy are dropped (counted if SWEEP_OVERRUN_CNT_EN).
module sweep_scheduler #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 7,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119,
  parameter int LAG    = 2
) (
  input  logic              newLocClock,
  input  logic              RESET_SIM_N,
  input  logic              run,
  input  logic              game_tick,
  input  logic              pause,
  output logic [X_BITS-1:0] view_x,
  output logic [Y_BITS-1:0] view_y,
  output logic [X_BITS-1:0] write_x,
  output logic [Y_BITS-1:0] write_y,
  output logic              write_flag,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [15:0]       frame_count,
  output logic [7:0]        overrun_count
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t            state_q;
  logic [X_BITS-1:0] vx_q, vx_d;
  logic [Y_BITS-1:0] vy_q, vy_d;
  logic [LAG-1:0]    pv_q;
  logic [X_BITS-1:0] px_q [LAG];
  logic [Y_BITS-1:0] py_q [LAG];
  logic              done_q;
  logic [15:0]       frame_q;

  logic at_row_end, at_last, upstream_vld;

  always_comb begin
    at_row_end = (vx_q == X_BITS'(X_MAX));
    at_last    = at_row_end && (vy_q == Y_BITS'(Y_MAX));
    vx_d       = at_row_end ? '0 : vx_q + X_BITS'(1);
    vy_d       = at_row_end ? vy_q + Y_BITS'(1) : vy_q;
    // Anything still valid ahead of the tail means the drain is not finished.
    upstream_vld = 1'b0;
    for (int i = 0; i < LAG - 1; i++) begin
      upstream_vld = upstream_vld | pv_q[i];
    end
  end

  always_ff @(posedge newLocClock) begin
    if (!RESET_SIM_N) begin
      state_q <= IDLE;
      vx_q    <= '0;
      vy_q    <= '0;
      pv_q    <= '0;
      for (int i = 0; i < LAG; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
      done_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && !run) begin
        state_q <= IDLE;
        vx_q    <= '0;
        vy_q    <= '0;
        pv_q    <= '0;
        for (int i = 0; i < LAG; i++) begin
          px_q[i] <= '0;
          py_q[i] <= '0;
        end
      end else begin
        if (state_q != IDLE && !pause) begin
          for (int i = LAG - 1; i > 0; i--) begin
            pv_q[i] <= pv_q[i-1];
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
          end
          pv_q[0] <= (state_q == SWEEP);
          px_q[0] <= vx_q;
          py_q[0] <= vy_q;
        end
        case (state_q)
          IDLE: begin
            if (game_tick && run) begin
              state_q <= SWEEP;
              vx_q    <= '0;
              vy_q    <= '0;
            end
          end
          SWEEP: begin
            if (!pause) begin
              if (at_last) begin
                state_q <= DRAIN;
              end else begin
                vx_q <= vx_d;
                vy_q <= vy_d;
              end
            end
          end
          DRAIN: begin
            if (!pause && !upstream_vld) begin
              state_q <= IDLE;
              vx_q    <= '0;
              vy_q    <= '0;
              done_q  <= 1'b1;
              frame_q <= frame_q + 16'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef SWEEP_OVERRUN_CNT_EN
  logic [7:0] ovr_q;

  always_ff @(posedge newLocClock) begin
    if (!RESET_SIM_N) begin
      ovr_q <= '0;
    end else if (state_q != IDLE && game_tick && ovr_q != 8'hFF) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign overrun_count = ovr_q;
`else
  assign overrun_count = '0;
`endif

  assign view_x      = vx_q;
  assign view_y      = vy_q;
  assign write_x     = px_q[LAG-1];
  assign write_y     = py_q[LAG-1];
  assign write_flag  = pv_q[LAG-1] & ~pause;
  assign sweep_busy  = (state_q != IDLE);
  assign sweep_done  = done_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler on a 4x3 grid with LAG=2.
module tb_sweep_scheduler;

  localparam int XB = 8;
  localparam int YB = 7;
`ifdef SWEEP_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, run, game_tick, pause;
  logic [XB-1:0] view_x, write_x;
  logic [YB-1:0] view_y, write_y;
  logic          write_flag, sweep_busy, sweep_done;
  logic [15:0]   frame_count;
  logic [7:0]    overrun_count;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         exp_frames = 0;
  logic [7:0] exp_ovr = 8'd0;

  always #5 clk = ~clk;

  sweep_scheduler #(
    .X_BITS(XB), .Y_BITS(YB), .X_MAX(3), .Y_MAX(2), .LAG(2)
  ) dut (
    .newLocClock  (clk),
    .RESET_SIM_N  (rst_n),
    .run          (run),
    .game_tick    (game_tick),
    .pause        (pause),
    .view_x       (view_x),
    .view_y       (view_y),
    .write_x      (write_x),
    .write_y      (write_y),
    .write_flag   (write_flag),
    .sweep_busy   (sweep_busy),
    .sweep_done   (sweep_done),
    .frame_count  (frame_count),
    .overrun_count(overrun_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b1; game_tick = 1'b0; pause = 1'b0;
    step; step; #1;
    tests_run++;
    if ({view_x, view_y} !== 15'd0) begin tests_failed++; $display("FAIL reset_view got (%0d,%0d) exp (0,0)", view_x, view_y); end
    tests_run++;
    if ({write_x, write_y} !== 15'd0) begin tests_failed++; $display("FAIL reset_write got (%0d,%0d) exp (0,0)", write_x, write_y); end
    tests_run++;
    if ({write_flag, sweep_busy, sweep_done} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b exp 000", {write_flag, sweep_busy, sweep_done}); end
    tests_run++;
    if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL reset_frame got %0d exp 0", frame_count); end
    tests_run++;
    if (overrun_count !== 8'd0) begin tests_failed++; $display("FAIL reset_overrun got %0d exp 0", overrun_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [XB-1:0] ex;
    logic [YB-1:0] ey;
    logic          ef;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step;
      game_tick = (c == 0);
      #1;
      if (c >= 1 && c <= 12) begin
        ex = XB'((c - 1) % 4); ey = YB'((c - 1) / 4);
        tests_run++;
        if ({view_x, view_y} !== {ex, ey}) begin tests_failed++; $display("FAIL basic_view c=%0d got (%0d,%0d) exp (%0d,%0d)", c, view_x, view_y, ex, ey); end
      end
      ef = (c >= 3 && c <= 14);
      tests_run++;
      if (write_flag !== ef) begin tests_failed++; $display("FAIL basic_flag c=%0d got %b exp %b", c, write_flag, ef); end
      if (ef) begin
        ex = XB'((c - 3) % 4); ey = YB'((c - 3) / 4);
        tests_run++;
        if ({write_x, write_y} !== {ex, ey}) begin tests_failed++; $display("FAIL basic_write c=%0d got (%0d,%0d) exp (%0d,%0d)", c, write_x, write_y, ex, ey); end
      end
      tests_run++;
      if (sweep_done !== (c == 15)) begin tests_failed++; $display("FAIL basic_done c=%0d got %b exp %b", c, sweep_done, (c == 15)); end
      tests_run++;
      if (sweep_busy !== (c >= 1 && c <= 14)) begin tests_failed++; $display("FAIL basic_busy c=%0d got %b exp %b", c, sweep_busy, (c >= 1 && c <= 14)); end
    end
    exp_frames++;
    tests_run++;
    if (frame_count !== 16'(exp_frames)) begin tests_failed++; $display("FAIL basic_frame got %0d exp %0d", frame_count, exp_frames); end
  endtask

  task automatic test_pause;
    int            nwr;
    logic [XB-1:0] ex;
    logic [YB-1:0] ey;
    logic          ef;
    nwr = 0;
    for (int c = 0; c <= 19; c++) begin
      if (c > 0) step;
      game_tick = (c == 0);
      pause     = (c >= 6 && c <= 8);
      #1;
      ef = (c >= 3 && c <= 5) || (c >= 9 && c <= 17);
      tests_run++;
      if (write_flag !== ef) begin tests_failed++; $display("FAIL pause_flag c=%0d got %b exp %b", c, write_flag, ef); end
      if (write_flag === 1'b1) begin
        ex = XB'(nwr % 4); ey = YB'(nwr / 4);
        tests_run++;
        if ({write_x, write_y} !== {ex, ey}) begin tests_failed++; $display("FAIL pause_order n=%0d got (%0d,%0d) exp (%0d,%0d)", nwr, write_x, write_y, ex, ey); end
        nwr++;
      end
      if (c == 7) begin
        tests_run++;
        if ({write_x, write_y} !== {8'd3, 7'd0}) begin tests_failed++; $display("FAIL pause_hold got (%0d,%0d) exp (3,0)", write_x, write_y); end
      end
      tests_run++;
      if (sweep_done !== (c == 18)) begin tests_failed++; $display("FAIL pause_done c=%0d got %b exp %b", c, sweep_done, (c == 18)); end
    end
    pause = 1'b0;
    tests_run++;
    if (nwr != 12) begin tests_failed++; $display("FAIL pause_count got %0d exp 12", nwr); end
    exp_frames++;
    tests_run++;
    if (frame_count !== 16'(exp_frames)) begin tests_failed++; $display("FAIL pause_frame got %0d exp %0d", frame_count, exp_frames); end
  endtask

  task automatic test_abort;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) step;
      game_tick = (c == 0);
      run       = (c != 7);
      #1;
      if (c == 7) begin
        tests_run++;
        if (sweep_busy !== 1'b1) begin tests_failed++; $display("FAIL abort_prebusy got %b exp 1", sweep_busy); end
      end
      if (c == 8) begin
        tests_run++;
        if ({view_x, view_y, write_x, write_y} !== 30'd0) begin tests_failed++; $display("FAIL abort_coords got v(%0d,%0d) w(%0d,%0d) exp all 0", view_x, view_y, write_x, write_y); end
        tests_run++;
        if (write_flag !== 1'b0) begin tests_failed++; $display("FAIL abort_flag got %b exp 0", write_flag); end
      end
      if (c >= 8) begin
        tests_run++;
        if ({sweep_busy, sweep_done} !== 2'b00) begin tests_failed++; $display("FAIL abort_idle c=%0d got busy/done %b exp 00", c, {sweep_busy, sweep_done}); end
      end
    end
    tests_run++;
    if (frame_count !== 16'(exp_frames)) begin tests_failed++; $display("FAIL abort_frame got %0d exp %0d", frame_count, exp_frames); end
  endtask

  task automatic test_extra_ticks;
    int dones;
    dones = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) step;
      game_tick = (c == 0 || c == 5 || c == 14);
      #1;
      if (sweep_done === 1'b1) dones++;
      tests_run++;
      if (sweep_busy !== (c >= 1 && c <= 14)) begin tests_failed++; $display("FAIL extra_busy c=%0d got %b exp %b", c, sweep_busy, (c >= 1 && c <= 14)); end
    end
    tests_run++;
    if (dones != 1) begin tests_failed++; $display("FAIL extra_dones got %0d exp 1", dones); end
    exp_frames++;
    exp_ovr = OVR_EN ? exp_ovr + 8'd2 : 8'd0;
    tests_run++;
    if (frame_count !== 16'(exp_frames)) begin tests_failed++; $display("FAIL extra_frame got %0d exp %0d", frame_count, exp_frames); end
    tests_run++;
    if (overrun_count !== exp_ovr) begin tests_failed++; $display("FAIL extra_overrun got %0d exp %0d", overrun_count, exp_ovr); end
  endtask

  // Tick held for 300 cycles: sweeps start every 15 cycles (0..285), 20 complete.
  task automatic test_back_to_back;
    int dones;
    dones = 0;
    for (int c = 0; c <= 305; c++) begin
      if (c > 0) step;
      game_tick = (c < 300);
      #1;
      if (sweep_done === 1'b1) dones++;
    end
    tests_run++;
    if (dones != 20) begin tests_failed++; $display("FAIL b2b_dones got %0d exp 20", dones); end
    exp_frames += 20;
    exp_ovr = OVR_EN ? 8'd255 : 8'd0;
    tests_run++;
    if (frame_count !== 16'(exp_frames)) begin tests_failed++; $display("FAIL b2b_frame got %0d exp %0d", frame_count, exp_frames); end
    tests_run++;
    if (overrun_count !== exp_ovr) begin tests_failed++; $display("FAIL b2b_overrun got %0d exp %0d", overrun_count, exp_ovr); end
    tests_run++;
    if (sweep_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got %b exp 0", sweep_busy); end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) step;
      game_tick = (c == 0);
      rst_n     = (c != 9);
      #1;
    end
    exp_frames = 0;
    exp_ovr    = 8'd0;
    tests_run++;
    if ({view_x, view_y, write_x, write_y} !== 30'd0) begin tests_failed++; $display("FAIL rstmid_coords got v(%0d,%0d) w(%0d,%0d) exp all 0", view_x, view_y, write_x, write_y); end
    tests_run++;
    if ({write_flag, sweep_busy, sweep_done} !== 3'b000) begin tests_failed++; $display("FAIL rstmid_flags got %b exp 000", {write_flag, sweep_busy, sweep_done}); end
    tests_run++;
    if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL rstmid_frame got %0d exp 0", frame_count); end
    tests_run++;
    if (overrun_count !== 8'd0) begin tests_failed++; $display("FAIL rstmid_overrun got %0d exp 0", overrun_count); end
  endtask

  task automatic test_tick_no_run;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) step;
      game_tick = (c == 0);
      run       = 1'b0;
      #1;
      if (c >= 1) begin
        tests_run++;
        if ({sweep_busy, write_flag} !== 2'b00) begin tests_failed++; $display("FAIL norun_idle c=%0d got busy/flag %b exp 00", c, {sweep_busy, write_flag}); end
        tests_run++;
        if ({view_x, view_y} !== 15'd0) begin tests_failed++; $display("FAIL norun_view c=%0d got (%0d,%0d) exp (0,0)", c, view_x, view_y); end
      end
    end
    run = 1'b1;
    tests_run++;
    if (overrun_count !== exp_ovr) begin tests_failed++; $display("FAIL norun_overrun got %0d exp %0d", overrun_count, exp_ovr); end
  endtask

  task automatic test_pause_idle;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step;
      game_tick = (c == 0);
      pause     = (c == 0);
      #1;
      if (c == 1) begin
        tests_run++;
        if (sweep_busy !== 1'b1) begin tests_failed++; $display("FAIL pidle_start got %b exp 1", sweep_busy); end
      end
      tests_run++;
      if (sweep_done !== (c == 15)) begin tests_failed++; $display("FAIL pidle_done c=%0d got %b exp %b", c, sweep_done, (c == 15)); end
    end
    exp_frames++;
    tests_run++;
    if (frame_count !== 16'(exp_frames)) begin tests_failed++; $display("FAIL pidle_frame got %0d exp %0d", frame_count, exp_frames); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_pause;
    test_abort;
    test_extra_ticks;
    test_back_to_back;
    test_reset_mid;
    test_tick_no_run;
    test_pause_idle;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
